// File: rtl/mul_arbiter.sv
// Round-robin front end that shares one pipelined multiplier among NUM_REQ requesters.
// A shadow (valid, id) pipeline runs in lockstep with the multiplier to tag each result.
module mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  parameter int STAGE   = 1,
  localparam int LAT    = STAGE + 1,
  localparam int IDW    = $clog2(NUM_REQ),
  localparam int CW     = $clog2(LAT + 1),
  localparam int WP     = WIDTH_A + WIDTH_B
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH_A-1:0] req_a,
  input  logic [NUM_REQ*WIDTH_B-1:0] req_b,
  output logic [WIDTH_A-1:0]         mul_a,
  output logic [WIDTH_B-1:0]         mul_b,
  output logic                       mul_pip_en,
  output logic                       mul_rst_n,
  input  logic [WP-1:0]              mul_out,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [WP-1:0]              rsp_data,
  input  logic                       rsp_ready,
  output logic [CW-1:0]              inflight
);

  logic [LAT-1:0] sh_valid;
  logic [IDW-1:0] sh_id [LAT];
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] hi_idx, lo_idx, gnt_idx, sel_idx, ptr_next;
  logic           hi_found, lo_found, gnt_any;

  assign rsp_valid  = sh_valid[LAT-1];
  assign rsp_id     = sh_id[LAT-1];
  assign rsp_data   = mul_out;
  assign mul_pip_en = ~rsp_valid | rsp_ready;
  assign mul_rst_n  = ~rst;

  // Two-pass priority search: lowest requester at/above rr_ptr wins, else wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
  end

  assign gnt_idx  = hi_found ? hi_idx : lo_idx;
  assign gnt_any  = lo_found & mul_pip_en & ~rst;
  assign sel_idx  = gnt_any ? gnt_idx : rr_ptr;
  assign ptr_next = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && gnt_idx == IDW'(i)) req_ready[i] = 1'b1;
      if (sel_idx == IDW'(i)) begin
        mul_a = req_a[i*WIDTH_A +: WIDTH_A];
        mul_b = req_b[i*WIDTH_B +: WIDTH_B];
      end
    end
  end

  // Shadow pipeline and occupancy count only move on edges where the multiplier moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_valid <= '0;
      for (int i = 0; i < LAT; i++) sh_id[i] <= '0;
      rr_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (mul_pip_en) begin
        for (int i = LAT - 1; i > 0; i--) begin
          sh_valid[i] <= sh_valid[i-1];
          sh_id[i]    <= sh_id[i-1];
        end
        sh_valid[0] <= gnt_any;
        sh_id[0]    <= gnt_idx;
        inflight    <= inflight + CW'(gnt_any) - CW'(sh_valid[LAT-1]);
      end
      if (gnt_any) rr_ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: behavioural multiplier, arbitration model and result scoreboard.
module tb_mul_arbiter;
  localparam int N     = 4;
  localparam int WA    = 16;
  localparam int WB    = 16;
  localparam int STAGE = 1;
  localparam int LAT   = STAGE + 1;
  localparam int IDW   = $clog2(N);
  localparam int CW    = $clog2(LAT + 1);
  localparam int WP    = WA + WB;

  logic              clk, rst;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*WA-1:0]   req_a;
  logic [N*WB-1:0]   req_b;
  logic [WA-1:0]     mul_a;
  logic [WB-1:0]     mul_b;
  logic              mul_pip_en, mul_rst_n;
  logic [WP-1:0]     mul_out;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [WP-1:0]     rsp_data;
  logic [CW-1:0]     inflight;

  mul_arbiter #(.NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .STAGE(STAGE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_pip_en(mul_pip_en), .mul_rst_n(mul_rst_n), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural LAT-stage multiplier driven by the arbiter's enable and reset.
  logic [WP-1:0] mpipe [LAT];
  always_ff @(posedge clk or negedge mul_rst_n) begin
    if (!mul_rst_n) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else if (mul_pip_en) begin
      mpipe[0] <= WP'(mul_a) * WP'(mul_b);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_out = mpipe[LAT-1];

  typedef struct {
    int            id;
    logic [WP-1:0] data;
  } sb_t;

  sb_t          sb_q[$];
  int           checks, failures;
  int           m_ptr, m_inflight;
  logic [LAT-1:0] m_valid;
  logic [WA-1:0] opa [N];
  logic [WB-1:0] opb [N];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: drive one cycle, check combinational and registered outputs, advance the model.
  task automatic applyStimulus(input logic [N-1:0] rv, input logic rr);
    int           g, idx;
    logic         found, en;
    logic [N-1:0] exp_ready;
    sb_t          e;
    req_valid = rv;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[i*WA +: WA] = opa[i];
      req_b[i*WB +: WB] = opb[i];
    end
    #1;
    en    = ~m_valid[LAT-1] | rr;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (!found && rv[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    exp_ready = '0;
    if (en && found) exp_ready[g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    checkOutput("mul_pip_en", 64'(mul_pip_en), 64'(en));
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_valid[LAT-1]));
    checkOutput("inflight", 64'(inflight), 64'(m_inflight));
    checkOutput("inflight_le_lat", 64'(int'(inflight) <= LAT), 64'd1);
    if (m_valid[LAT-1]) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_underflow", 64'd1, 64'd0);
      end else begin
        checkOutput("rsp_id", 64'(rsp_id), 64'(sb_q[0].id));
        checkOutput("rsp_data", 64'(rsp_data), 64'(sb_q[0].data));
      end
    end
    if (en) begin
      if (m_valid[LAT-1] && sb_q.size() > 0) void'(sb_q.pop_front());
      m_valid = (m_valid << 1) | LAT'(found);
      if (found) begin
        e.id   = g;
        e.data = WP'(opa[g]) * WP'(opb[g]);
        sb_q.push_back(e);
        m_ptr  = (g + 1) % N;
        opa[g] = WA'($urandom);
        opb[g] = WB'($urandom);
      end
      m_inflight = $countones(m_valid);
    end
    @(negedge clk);
  endtask

  task automatic doReset(input logic [N-1:0] rv);
    req_valid = rv;
    rsp_ready = 1'b1;
    rst       = 1'b1;
    #1;
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_inflight", 64'(inflight), 64'd0);
    checkOutput("rst_mul_rst_n", 64'(mul_rst_n), 64'd0);
    m_valid    = '0;
    m_ptr      = 0;
    m_inflight = 0;
    sb_q.delete();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 2; i++) applyStimulus('0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0; failures = 0;
    m_ptr = 0; m_inflight = 0; m_valid = '0;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin
      opa[i] = WA'($urandom);
      opb[i] = WB'($urandom);
    end
    @(negedge clk);
    doReset('0);

    $display("[TB] single request 3*5 from requester 1");
    opa[1] = 16'd3; opb[1] = 16'd5;
    applyStimulus(4'b0010, 1'b1);
    drain();

    $display("[TB] round-robin with all requesters active");
    doReset('0);
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1'b1);
    drain();

    $display("[TB] backpressure and withdrawn request");
    doReset('0);
    for (int i = 0; i < 2; i++) applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b0011, 1'b0);
    applyStimulus(4'b0011, 1'b0);
    applyStimulus(4'b0011, 1'b1);
    drain();

    $display("[TB] pointer skip");
    doReset('0);
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b0101, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    drain();

    $display("[TB] bubbles");
    for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1);
    drain();

    $display("[TB] mid-flight reset");
    applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("pre_rst_inflight", 64'(inflight), 64'd2);
    doReset(4'b1111);
    applyStimulus(4'b0010, 1'b1);
    drain();

    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
